// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - command/reply codes and parser states for uart_bridge
package uart_bridge_pkg;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h06;
   localparam logic [7:0] NAK    = 8'h15;

   // Inter-byte timeout, in bit times
   localparam int TIMEOUT_BITS = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA,
      ST_BUS,
      ST_REPLY
   } parser_state_e;

endpackage

// File: rtl/uart_bridge_rx.sv
// rtl/uart_bridge_rx.sv - 8N1 receiver with input synchronizer and false-start rejection
module uart_bridge_rx #(
   parameter int CPB = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int CW = $clog2(CPB);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   rx_state_e     rx_state_q;
   logic          sync1_q;
   logic          sync2_q;
   logic          prev_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q;
   logic          valid_q;
   logic          err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         cnt_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (prev_q && !sync2_q) begin
                  rx_state_q <= RX_START;
                  cnt_q      <= '0;
               end
            end
            RX_START: begin
               // Mid-start re-check rejects glitches shorter than half a bit
               if (cnt_q == CW'(CPB / 2 - 1)) begin
                  cnt_q      <= '0;
                  bit_q      <= '0;
                  rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == CW'(CPB - 1)) begin
                  cnt_q <= '0;
                  sh_q  <= {sync2_q, sh_q[7:1]};
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == CW'(CPB - 1)) begin
                  cnt_q      <= '0;
                  valid_q    <= sync2_q;
                  err_q      <= !sync2_q;
                  rx_state_q <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign byte_o       = sh_q;
   assign byte_valid_o = valid_q;
   assign frame_err_o  = err_q;

endmodule

// File: rtl/uart_bridge.sv
// rtl/uart_bridge.sv - UART command bridge issuing single-word bus reads and writes
// Parser, bus strobe and reply transmitter share one registered FSM.
module uart_bridge
   import uart_bridge_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CPB   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RxD,
   output logic             TxD,
   output logic             mem_cs,
   output logic             mem_wen,
   output logic [15:0]      mem_addr,
   output logic [WIDTH-1:0] mem_dout,
   input  logic [WIDTH-1:0] mem_din,
   output logic             active
);

   localparam int CW        = $clog2(CPB);
   localparam int TO_CYCLES = TIMEOUT_BITS * CPB;
   localparam int TW        = $clog2(TO_CYCLES) + 1;

   logic [7:0]       rx_byte;
   logic             rx_valid;
   logic             rx_err;

   parser_state_e    state_q;
   logic             is_wr_q;
   logic [15:0]      addr_q;
   logic [23:0]      data_sh_q;
   logic [1:0]       dcnt_q;
   logic [TW-1:0]    tout_q;
   logic             mem_cs_q;
   logic             mem_wen_q;
   logic [15:0]      mem_addr_q;
   logic [WIDTH-1:0] mem_dout_q;
   logic [23:0]      reply_q;
   logic [1:0]       left_q;
   logic [7:0]       tx_sh_q;
   logic [3:0]       tx_bit_q;
   logic [CW-1:0]    tx_cnt_q;
   logic             txd_q;
   logic             active_q;
   logic             receiving;

   uart_bridge_rx #(.CPB(CPB)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .rxd_i        (RxD),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_err)
   );

   assign receiving = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) || (state_q == ST_DATA);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         data_sh_q  <= '0;
         dcnt_q     <= '0;
         tout_q     <= '0;
         mem_cs_q   <= 1'b0;
         mem_wen_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_dout_q <= '0;
         reply_q    <= '0;
         left_q     <= '0;
         tx_sh_q    <= '0;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
         txd_q      <= 1'b1;
         active_q   <= 1'b0;
      end else begin
         mem_cs_q  <= 1'b0;
         mem_wen_q <= 1'b0;
         tout_q    <= (receiving && !rx_valid) ? tout_q + 1'b1 : '0;
         // Framing error or a stalled host abandons a partial command silently
         if (receiving && (rx_err || (!rx_valid && tout_q == TW'(TO_CYCLES - 1)))) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (rx_valid) begin
                     active_q <= 1'b1;
                     if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                        is_wr_q <= (rx_byte == CMD_WR);
                        state_q <= ST_ADDR_HI;
                     end else begin
                        txd_q    <= 1'b0;
                        tx_sh_q  <= NAK;
                        tx_bit_q <= '0;
                        tx_cnt_q <= '0;
                        left_q   <= '0;
                        state_q  <= ST_REPLY;
                     end
                  end
               end
               ST_ADDR_HI: begin
                  if (rx_valid) begin
                     addr_q[15:8] <= rx_byte;
                     state_q      <= ST_ADDR_LO;
                  end
               end
               ST_ADDR_LO: begin
                  if (rx_valid) begin
                     addr_q[7:0] <= rx_byte;
                     if (is_wr_q) begin
                        dcnt_q  <= 2'd3;
                        state_q <= ST_DATA;
                     end else begin
                        mem_addr_q <= {addr_q[15:8], rx_byte};
                        mem_cs_q   <= 1'b1;
                        state_q    <= ST_BUS;
                     end
                  end
               end
               ST_DATA: begin
                  if (rx_valid) begin
                     data_sh_q <= {data_sh_q[15:0], rx_byte};
                     if (dcnt_q == 2'd0) begin
                        mem_addr_q <= addr_q;
                        mem_dout_q <= {data_sh_q, rx_byte};
                        mem_cs_q   <= 1'b1;
                        mem_wen_q  <= 1'b1;
                        state_q    <= ST_BUS;
                     end else begin
                        dcnt_q <= dcnt_q - 2'd1;
                     end
                  end
               end
               ST_BUS: begin
                  txd_q    <= 1'b0;
                  tx_bit_q <= '0;
                  tx_cnt_q <= '0;
                  state_q  <= ST_REPLY;
                  if (is_wr_q) begin
                     tx_sh_q <= ACK;
                     left_q  <= 2'd0;
                  end else begin
                     tx_sh_q <= mem_din[31:24];
                     reply_q <= mem_din[23:0];
                     left_q  <= 2'd3;
                  end
               end
               ST_REPLY: begin
                  // tx_bit_q: 0 start, 1..8 data LSB first, 9 stop
                  if (tx_cnt_q != CW'(CPB - 1)) begin
                     tx_cnt_q <= tx_cnt_q + 1'b1;
                  end else begin
                     tx_cnt_q <= '0;
                     if (tx_bit_q == 4'd9) begin
                        if (left_q != 2'd0) begin
                           txd_q    <= 1'b0;
                           tx_bit_q <= '0;
                           tx_sh_q  <= reply_q[23:16];
                           reply_q  <= {reply_q[15:0], 8'h00};
                           left_q   <= left_q - 2'd1;
                        end else begin
                           state_q  <= ST_IDLE;
                           active_q <= 1'b0;
                        end
                     end else begin
                        tx_bit_q <= tx_bit_q + 4'd1;
                        if (tx_bit_q == 4'd8) begin
                           txd_q <= 1'b1;
                        end else begin
                           txd_q   <= tx_sh_q[0];
                           tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                        end
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign TxD      = txd_q;
   assign mem_cs   = mem_cs_q;
   assign mem_wen  = mem_wen_q;
   assign mem_addr = mem_addr_q;
   assign mem_dout = mem_dout_q;
   assign active   = active_q;

endmodule
